// File: rtl/fifo_w1_r16_64_pkg.sv
// Shared widths and types for the 1-bit-in / 16-bit-out buffering FIFO.
package fifo_w1_r16_pkg;

    localparam int unsigned DATA_W   = 16;
    localparam int unsigned DEPTH    = 4;
    localparam int unsigned PTR_W    = $clog2(DEPTH);
    localparam int unsigned LVL_W    = PTR_W + 1;
    localparam int unsigned BITCNT_W = $clog2(DATA_W);

    typedef logic [DATA_W-1:0]   word_t;
    typedef logic [PTR_W-1:0]    ptr_t;
    typedef logic [LVL_W-1:0]    lvl_t;
    typedef logic [BITCNT_W-1:0] bitcnt_t;

endpackage : fifo_w1_r16_pkg

// File: rtl/fifo_w1_r16_64_if.sv
// Handshake/data bundle of the serial-to-parallel FIFO.
//   master: serial writer + word reader (drives din, wr_en, rd_en)
//   slave : the FIFO (drives dout, full, empty, level, bit_cnt, ovf, udf)
interface fifo_w1_r16_64_if;
    import fifo_w1_r16_pkg::*;

    logic    din;
    logic    wr_en;
    logic    rd_en;
    word_t   dout;
    logic    full;
    logic    empty;
    lvl_t    level;
    bitcnt_t bit_cnt;
    logic    ovf;
    logic    udf;

    modport master (
        output din, wr_en, rd_en,
        input  dout, full, empty, level, bit_cnt, ovf, udf
    );

    modport slave (
        input  din, wr_en, rd_en,
        output dout, full, empty, level, bit_cnt, ovf, udf
    );
endinterface : fifo_w1_r16_64_if

// File: rtl/fifo_w1_r16_64_sipo.sv
// MSB-first shift accumulator with bit counter.
//   clk, rst_n     : clock, synchronous active-low reset
//   en_i, din_i    : accept din_i this edge when en_i
//   word_c_o       : completed word {acc[14:0], din_i} (valid with word_valid_c_o)
//   word_valid_c_o : high in the cycle whose edge accepts the 16th bit
//   bit_cnt_o      : bits held in the partial word
module sipo_w1_16
    import fifo_w1_r16_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    en_i,
    input  logic    din_i,
    output word_t   word_c_o,
    output logic    word_valid_c_o,
    output bitcnt_t bit_cnt_o
);

    word_t   acc_q,     acc_d;
    bitcnt_t bit_cnt_q, bit_cnt_d;

    // Completed word is presented combinationally so the top writes it on the same edge.
    assign word_c_o       = {acc_q[DATA_W-2:0], din_i};
    assign word_valid_c_o = en_i && (bit_cnt_q == BITCNT_W'(DATA_W - 1));
    assign bit_cnt_o      = bit_cnt_q;

    always_comb begin
        acc_d     = acc_q;
        bit_cnt_d = bit_cnt_q;
        if (en_i) begin
            acc_d     = {acc_q[DATA_W-2:0], din_i};
            bit_cnt_d = BITCNT_W'(bit_cnt_q + 1'b1);  // wraps 15 -> 0
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q     <= '0;
            bit_cnt_q <= '0;
        end else begin
            acc_q     <= acc_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

endmodule : sipo_w1_16

// File: rtl/fifo_w1_r16_64.sv
// Serial-to-parallel FIFO: 1-bit MSB-first writes, 16-bit word reads, 4 words deep.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : slave side of fifo_w1_r16_64_if (din/wr_en/rd_en in; dout, flags,
//                level, bit_cnt, ovf/udf pulses out, all registered)
module fifo_w1_r16_64
    import fifo_w1_r16_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    fifo_w1_r16_64_if.slave  bus
);

    word_t   mem_q [DEPTH];
    ptr_t    wr_ptr_q, wr_ptr_d;
    ptr_t    rd_ptr_q, rd_ptr_d;
    lvl_t    level_q,  level_d;
    word_t   dout_q,   dout_d;
    logic    full_q,   full_d;
    logic    empty_q,  empty_d;
    logic    ovf_q,    ovf_d;
    logic    udf_q,    udf_d;

    logic    sipo_en_c;
    word_t   word_c;
    logic    push_c;
    logic    pop_c;
    bitcnt_t bit_cnt_w;

    // Full rejects every bit, independent of a same-cycle pop.
    assign sipo_en_c = bus.wr_en && !full_q;
    assign pop_c     = bus.rd_en && !empty_q;

    sipo_w1_16 u_sipo (
        .clk            (clk),
        .rst_n          (rst_n),
        .en_i           (sipo_en_c),
        .din_i          (bus.din),
        .word_c_o       (word_c),
        .word_valid_c_o (push_c),
        .bit_cnt_o      (bit_cnt_w)
    );

    // Next-state pointers, level, flags and read data.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        dout_d   = dout_q;
        ovf_d    = bus.wr_en && full_q;
        udf_d    = bus.rd_en && empty_q;
        if (push_c) wr_ptr_d = PTR_W'(wr_ptr_q + 1'b1);
        if (pop_c) begin
            rd_ptr_d = PTR_W'(rd_ptr_q + 1'b1);
            dout_d   = mem_q[rd_ptr_q];
        end
        case ({push_c, pop_c})
            2'b10:   level_d = LVL_W'(level_q + 1'b1);
            2'b01:   level_d = LVL_W'(level_q - 1'b1);
            default: level_d = level_q;
        endcase
        full_d  = (level_d == LVL_W'(DEPTH));
        empty_d = (level_d == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            dout_q   <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            dout_q   <= dout_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Word storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push_c) mem_q[wr_ptr_q] <= word_c;
    end

    assign bus.dout    = dout_q;
    assign bus.full    = full_q;
    assign bus.empty   = empty_q;
    assign bus.level   = level_q;
    assign bus.bit_cnt = bit_cnt_w;
    assign bus.ovf     = ovf_q;
    assign bus.udf     = udf_q;

endmodule : fifo_w1_r16_64

// File: tb/tb_fifo_w1_r16_64.sv
// Directed self-checking bench for fifo_w1_r16_64.
module tb_fifo_w1_r16_64;
    import fifo_w1_r16_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;
    logic [15:0] exp_q[$];

    fifo_w1_r16_64_if bus ();

    fifo_w1_r16_64 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        bus.din   = 1'b0;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    // Shift a word in MSB-first, 1 bit/clk; optionally raise rd_en on the 16th bit.
    task automatic write_word(input logic [15:0] w, input bit rd_on_last);
        for (int i = 15; i >= 0; i--) begin
            bus.din   = w[i];
            bus.wr_en = 1'b1;
            bus.rd_en = (i == 0) && rd_on_last;
            step();
        end
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.dout !== 16'h0000) begin errors++; $display("FAIL reset_dout: got %h want 0000", bus.dout); end
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", bus.empty); end
        checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", bus.full); end
        checks++; if (bus.level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", bus.level); end
        checks++; if (bus.bit_cnt !== 4'd0) begin errors++; $display("FAIL reset_bit_cnt: got %0d want 0", bus.bit_cnt); end
        checks++; if ({bus.ovf, bus.udf} !== 2'b00) begin errors++; $display("FAIL reset_pulses: got %b want 00", {bus.ovf, bus.udf}); end
    endtask

    task automatic test_single_word();
        write_word(16'hBBBB, 1'b0);
        checks++; if (bus.empty !== 1'b0) begin errors++; $display("FAIL single_empty_fall: got %b want 0", bus.empty); end
        checks++; if (bus.level !== 3'd1) begin errors++; $display("FAIL single_level: got %0d want 1", bus.level); end
        bus.rd_en = 1'b1;
        step();
        bus.rd_en = 1'b0;
        checks++; if (bus.dout !== 16'hBBBB) begin errors++; $display("FAIL single_dout: got %h want bbbb", bus.dout); end
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL single_empty_back: got %b want 1", bus.empty); end
    endtask

    task automatic test_full_ovf();
        logic [15:0] words [4];
        words[0] = 16'hFFFF; words[1] = 16'h0000; words[2] = 16'hBBBB; words[3] = 16'h1234;
        for (int k = 0; k < 4; k++) write_word(words[k], 1'b0);
        checks++; if (bus.full !== 1'b1) begin errors++; $display("FAIL full_flag: got %b want 1", bus.full); end
        checks++; if (bus.level !== 3'd4) begin errors++; $display("FAIL full_level: got %0d want 4", bus.level); end
        bus.din   = 1'b1;
        bus.wr_en = 1'b1;
        step();
        bus.wr_en = 1'b0;
        checks++; if (bus.ovf !== 1'b1) begin errors++; $display("FAIL ovf_pulse: got %b want 1", bus.ovf); end
        checks++; if (bus.bit_cnt !== 4'd0) begin errors++; $display("FAIL ovf_bit_cnt: got %0d want 0", bus.bit_cnt); end
        step();
        checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL ovf_one_cycle: got %b want 0", bus.ovf); end
        // Back-to-back reads, one word per clock.
        bus.rd_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            checks++; if (bus.dout !== words[k]) begin errors++; $display("FAIL full_read%0d: got %h want %h", k, bus.dout, words[k]); end
            if (k == 0) begin
                checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL full_fall: got %b want 0", bus.full); end
            end
        end
        bus.rd_en = 1'b0;
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL drained_empty: got %b want 1", bus.empty); end
    endtask

    task automatic test_underflow();
        bus.rd_en = 1'b1;
        step();
        bus.rd_en = 1'b0;
        checks++; if (bus.udf !== 1'b1) begin errors++; $display("FAIL udf_pulse: got %b want 1", bus.udf); end
        checks++; if (bus.dout !== 16'h1234) begin errors++; $display("FAIL udf_dout_hold: got %h want 1234", bus.dout); end
        checks++; if (bus.level !== 3'd0) begin errors++; $display("FAIL udf_level: got %0d want 0", bus.level); end
        step();
        checks++; if (bus.udf !== 1'b0) begin errors++; $display("FAIL udf_one_cycle: got %b want 0", bus.udf); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] want;
        for (int k = 1; k <= 3; k++) begin
            write_word(16'(k), 1'b0);
            exp_q.push_back(16'(k));
        end
        // Words 4..10 each complete on the same edge as a read.
        for (int k = 4; k <= 10; k++) begin
            write_word(16'(k), 1'b1);
            want = exp_q.pop_front();
            exp_q.push_back(16'(k));
            checks++; if (bus.dout !== want) begin errors++; $display("FAIL wrap_read_w%0d: got %h want %h", k, bus.dout, want); end
            checks++; if (bus.level !== 3'd3) begin errors++; $display("FAIL wrap_level_w%0d: got %0d want 3", k, bus.level); end
        end
        bus.rd_en = 1'b1;
        while (exp_q.size() > 0) begin
            step();
            want = exp_q.pop_front();
            checks++; if (bus.dout !== want) begin errors++; $display("FAIL wrap_drain: got %h want %h", bus.dout, want); end
        end
        bus.rd_en = 1'b0;
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL wrap_empty: got %b want 1", bus.empty); end
    endtask

    task automatic test_reset_partial();
        for (int i = 0; i < 7; i++) begin
            bus.din   = 1'b1;
            bus.wr_en = 1'b1;
            step();
        end
        bus.wr_en = 1'b0;
        checks++; if (bus.bit_cnt !== 4'd7) begin errors++; $display("FAIL partial_bit_cnt: got %0d want 7", bus.bit_cnt); end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checks++; if (bus.bit_cnt !== 4'd0) begin errors++; $display("FAIL partial_reset: got %0d want 0", bus.bit_cnt); end
        write_word(16'hA5A5, 1'b0);
        bus.rd_en = 1'b1;
        step();
        bus.rd_en = 1'b0;
        checks++; if (bus.dout !== 16'hA5A5) begin errors++; $display("FAIL partial_residue: got %h want a5a5", bus.dout); end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_full_ovf();
        test_underflow();
        test_back_to_back();
        test_reset_partial();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_fifo_w1_r16_64
